dmem_loader: RTL and testbench

- Streams an input word sequence, e.g. the unsorted numbers for the isort program, into single_cycle_mips data memory through a valid/ready handshake.
- Holds the CPU in reset while loading.
- Releases the CPU once NUM_WORDS words have been committed.
- Sits beside cpu.dmem in the top level and drives its write port in place of testbench preloading.

---
 rtl/dmem_loader_pkg.sv | 25 ++
 rtl/dmem_loader_if.sv | 51 +++++
 rtl/dmem_loader.sv | 149 ++++++++++++++
 tb/tb_dmem_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_loader_pkg
//  Description : Shared types and default constants for the dmem loader.
//                The default load window (word 32, 96 words) matches the
//                unsorted-number region used by the isort program.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_loader_pkg;

    // Loader FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default load window shared with the isort testbench
    localparam int c_DEF_BASE_WORD = 32;
    localparam int c_DEF_NUM_WORDS = 96;
    localparam int c_DEF_ADDR_W    = 10;
    localparam int c_DEF_DATA_W    = 32;

endpackage : dmem_loader_pkg
`default_nettype wire

// File: rtl/dmem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_loader_if
//  Description : Producer handshake, dmem write port and status bundle for
//                the dmem loader. The slave modport is the loader side; the
//                master modport is the producer / top-level side.
//                Optional macro DMEM_LOADER_CHECKSUM_EN adds a checksum signal.
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_loader_if
    import dmem_loader_pkg::*;
#(
    parameter int ADDR_W    = c_DEF_ADDR_W,
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int NUM_WORDS = c_DEF_NUM_WORDS
);
    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
`ifdef DMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, count
`ifdef DMEM_LOADER_CHECKSUM_EN
        , output checksum
`endif
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, count
`ifdef DMEM_LOADER_CHECKSUM_EN
        , input checksum
`endif
    );

endinterface : dmem_loader_if
`default_nettype wire

// File: rtl/dmem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_loader
//  Description : Streams NUM_WORDS words from a valid/ready producer into
//                data memory starting at BASE_WORD, holding the CPU in reset
//                until the final write has been committed.
//                Optional macro DMEM_LOADER_CHECKSUM_EN adds a running sum of
//                accepted words on the checksum output.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_loader
    import dmem_loader_pkg::*;
#(
    parameter int BASE_WORD = c_DEF_BASE_WORD,
    parameter int NUM_WORDS = c_DEF_NUM_WORDS,
    parameter int ADDR_W    = c_DEF_ADDR_W,
    parameter int DATA_W    = c_DEF_DATA_W
) (
    input  wire              clk,
    input  wire              reset,
    dmem_loader_if.slave     bus
);
    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    // Parameter sanity: the load window must fit in the dmem address space
    generate
        if (NUM_WORDS < 1) begin : g_num_words_err
            $error("dmem_loader: NUM_WORDS must be at least 1");
        end
        if (BASE_WORD + NUM_WORDS > (1 << ADDR_W)) begin : g_addr_range_err
            $error("dmem_loader: BASE_WORD+NUM_WORDS exceeds 2**ADDR_W");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              w_xfer;
`ifdef DMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

    // A word is taken whenever the producer is valid while we sit in LOAD
    assign w_xfer = (state_q == ST_LOAD) && bus.in_valid;

    // Next-state and next-output decode; the write port is fully registered
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
`ifdef DMEM_LOADER_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
`ifdef DMEM_LOADER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (w_xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(BASE_WORD) + ADDR_W'(count_q);
                    mem_wdata_d = bus.in_data;
                    if (count_q != CNT_W'(NUM_WORDS)) begin
                        count_d = count_q + CNT_W'(1);
                    end
`ifdef DMEM_LOADER_CHECKSUM_EN
                    checksum_d = checksum_q + bus.in_data;
`endif
                    if (count_q == CNT_W'(NUM_WORDS - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // The first edge here commits the last write, so the CPU is
                // released on exactly that edge.
                cpu_reset_d = 1'b0;
                done_d      = 1'b1;
                if (bus.start) begin
                    state_d     = ST_LOAD;
                    count_d     = '0;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
`ifdef DMEM_LOADER_CHECKSUM_EN
                    checksum_d  = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
`ifdef DMEM_LOADER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
`ifdef DMEM_LOADER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.busy      = (state_q == ST_LOAD);
    assign bus.done      = done_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.count     = count_q;
`ifdef DMEM_LOADER_CHECKSUM_EN
    assign bus.checksum  = checksum_q;
`endif

endmodule : dmem_loader
`default_nettype wire

// File: tb/tb_dmem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_loader
//  Description : Directed self-checking bench for dmem_loader. A second
//                instance with NUM_WORDS=1, BASE_WORD=5 covers the single
//                word run. Optional macro DMEM_LOADER_CHECKSUM_EN enables the
//                checksum scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_loader;
    localparam int CW  = $clog2(96 + 1);
    localparam int CW1 = $clog2(1 + 1);

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    dmem_loader_if #(.ADDR_W(10), .DATA_W(32), .NUM_WORDS(96)) bus ();
    dmem_loader_if #(.ADDR_W(10), .DATA_W(32), .NUM_WORDS(1))  bus1 ();

    dmem_loader #(.BASE_WORD(32), .NUM_WORDS(96), .ADDR_W(10), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dmem_loader #(.BASE_WORD(5), .NUM_WORDS(1), .ADDR_W(10), .DATA_W(32)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    // Data memory model fed by the loader write port
    logic [31:0] dmem [0:1023];
    logic        dmem_clr = 1'b0;
    always @(posedge clk) begin
        if (dmem_clr) begin
            for (int k = 0; k < 1024; k++) dmem[k] <= 32'h0;
        end else if (bus.mem_we) begin
            dmem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dmem();
        dmem_clr = 1'b1;
        tick();
        dmem_clr = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Reset held 3 cycles with start asserted; reset must win
    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h1234;
        bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = 32'h0;
        repeat (3) tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h exp=0", bus.in_ready); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%0h exp=0", bus.mem_we); end
        total++; if (bus.mem_addr !== 10'd0) begin bad++; $display("FAIL rst_mem_addr got=%0h exp=0", bus.mem_addr); end
        total++; if (bus.mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_mem_wdata got=%0h exp=0", bus.mem_wdata); end
        total++; if (bus.cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset got=%0h exp=1", bus.cpu_reset); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0h exp=0", bus.done); end
        total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
`ifdef DMEM_LOADER_CHECKSUM_EN
        total++; if (bus.checksum !== 32'd0) begin bad++; $display("FAIL rst_checksum got=%0h exp=0", bus.checksum); end
`endif
        // Released from reset with start low: stay IDLE, in_valid ignored
        reset = 1'b0; bus.start = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0h exp=0", bus.busy); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL idle_mem_we got=%0h exp=0", bus.mem_we); end
        bus.in_valid = 1'b0;
    endtask

    // 96 words 0x60..0x01 without gaps, starting from IDLE
    task automatic test_back_to_back();
        int errs = 0;
        clear_dmem();
        pulse_start();
        total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_enter got=%0h%0h exp=11", bus.in_ready, bus.busy); end
        for (int i = 0; i < 96; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'(96 - i);
            tick();
            total++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'(32 + i) || bus.mem_wdata !== 32'(96 - i) ||
                bus.count !== CW'(i + 1) || bus.cpu_reset !== 1'b1) begin
                bad++;
                $display("FAIL b2b_write[%0d] got we=%0h a=%0d d=%0h c=%0d cr=%0h exp we=1 a=%0d d=%0h c=%0d cr=1",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.count, bus.cpu_reset, 32 + i, 96 - i, i + 1);
            end
        end
        total++; if (bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL b2b_last got rdy=%0h done=%0h exp 0 0", bus.in_ready, bus.done); end
        bus.in_valid = 1'b0;
        tick();
        total++; if (bus.mem_we !== 1'b0 || bus.cpu_reset !== 1'b0 || bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done got we=%0h cr=%0h done=%0h exp 0 0 1", bus.mem_we, bus.cpu_reset, bus.done); end
        total++; if (bus.count !== CW'(96)) begin bad++; $display("FAIL b2b_count got=%0d exp=96", bus.count); end
        total++; if (dmem[32] !== 32'h60 || dmem[127] !== 32'h01) begin bad++; $display("FAIL b2b_dmem_ends got=%0h,%0h exp=60,1", dmem[32], dmem[127]); end
        for (int i = 0; i < 96; i++) if (dmem[32 + i] !== 32'(96 - i)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_dmem got_errs=%0d exp=0", errs); end
    endtask

    // Same stream with a one-cycle gap after every word, restarted from DONE
    task automatic test_stalls();
        int errs = 0;
        clear_dmem();
        pulse_start();
        total++; if (bus.done !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.count !== CW'(0)) begin bad++; $display("FAIL stall_restart got done=%0h cr=%0h c=%0d exp 0 1 0", bus.done, bus.cpu_reset, bus.count); end
        for (int i = 0; i < 96; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'(96 - i);
            tick();
            total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'(32 + i)) begin bad++; $display("FAIL stall_write[%0d] got we=%0h a=%0d exp we=1 a=%0d", i, bus.mem_we, bus.mem_addr, 32 + i); end
            bus.in_valid = 1'b0; bus.in_data = 32'hDEAD_BEEF;
            tick();
            total++;
            if (bus.mem_we !== 1'b0 || bus.mem_addr !== 10'(32 + i) || bus.mem_wdata !== 32'(96 - i) || bus.count !== CW'(i + 1)) begin
                bad++;
                $display("FAIL stall_gap[%0d] got we=%0h a=%0d d=%0h c=%0d exp we=0 a=%0d d=%0h c=%0d",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.count, 32 + i, 96 - i, i + 1);
            end
        end
        total++; if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0) begin bad++; $display("FAIL stall_done got done=%0h cr=%0h exp 1 0", bus.done, bus.cpu_reset); end
        for (int i = 0; i < 96; i++) if (dmem[32 + i] !== 32'(96 - i)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL stall_dmem got_errs=%0d exp=0", errs); end
    endtask

    // Reload from DONE with 0xAAAA0000+i; CPU held throughout
    task automatic test_reload_done();
        int errs = 0;
        int cr_errs = 0;
        pulse_start();
        total++; if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL reload_enter got cr=%0h done=%0h busy=%0h exp 1 0 1", bus.cpu_reset, bus.done, bus.busy); end
        for (int i = 0; i < 96; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'hAAAA_0000 + 32'(i);
            tick();
            if (bus.cpu_reset !== 1'b1) cr_errs++;
        end
        total++; if (cr_errs != 0) begin bad++; $display("FAIL reload_cpu_reset got_low_cycles=%0d exp=0", cr_errs); end
        bus.in_valid = 1'b0;
        tick();
        total++; if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0) begin bad++; $display("FAIL reload_done got done=%0h cr=%0h exp 1 0", bus.done, bus.cpu_reset); end
        for (int i = 0; i < 96; i++) if (dmem[32 + i] !== 32'hAAAA_0000 + 32'(i)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL reload_dmem got_errs=%0d exp=0", errs); end
    endtask

    // start pulsed with the transfer taken at count=40 must not restart
    task automatic test_start_ignored();
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'(96 - i);
            bus.start = (i == 40);
            tick();
            if (i >= 40) begin
                total++; if (bus.count !== CW'(i + 1) || bus.mem_addr !== 10'(32 + i)) begin bad++; $display("FAIL ign_start[%0d] got c=%0d a=%0d exp c=%0d a=%0d", i, bus.count, bus.mem_addr, i + 1, 32 + i); end
            end
        end
        bus.start = 1'b0;
    endtask

    // Reset at count=50 with a write pending, then a clean reload
    task automatic test_reset_mid();
        int errs = 0;
        total++; if (bus.mem_we !== 1'b1 || bus.count !== CW'(50)) begin bad++; $display("FAIL mid_pre got we=%0h c=%0d exp 1 50", bus.mem_we, bus.count); end
        clear_dmem();
        reset = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h5555_5555;
        tick();
        total++; if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.count !== CW'(0)) begin bad++; $display("FAIL mid_reset got we=%0h busy=%0h cr=%0h c=%0d exp 0 0 1 0", bus.mem_we, bus.busy, bus.cpu_reset, bus.count); end
        reset = 1'b0; bus.in_valid = 1'b0;
        pulse_start();
        for (int i = 0; i < 96; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'(96 - i);
            tick();
            if (i == 0) begin
                total++; if (bus.mem_addr !== 10'd32 || bus.mem_we !== 1'b1) begin bad++; $display("FAIL mid_first got a=%0d we=%0h exp a=32 we=1", bus.mem_addr, bus.mem_we); end
            end
        end
        bus.in_valid = 1'b0;
        tick();
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL mid_done got=%0h exp=1", bus.done); end
        for (int i = 0; i < 96; i++) if (dmem[32 + i] !== 32'(96 - i)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL mid_dmem got_errs=%0d exp=0", errs); end
    endtask

    // NUM_WORDS=1: a single transfer finishes the run
    task automatic test_num_words_one();
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL one_ready got=%0h exp=1", bus1.in_ready); end
        bus1.in_valid = 1'b1; bus1.in_data = 32'hDEAD_BEEF;
        tick();
        bus1.in_valid = 1'b0;
        total++; if (bus1.mem_we !== 1'b1 || bus1.mem_addr !== 10'd5 || bus1.mem_wdata !== 32'hDEAD_BEEF || bus1.busy !== 1'b0 || bus1.count !== CW1'(1)) begin bad++; $display("FAIL one_write got we=%0h a=%0d d=%0h busy=%0h c=%0d exp 1 5 deadbeef 0 1", bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.busy, bus1.count); end
        tick();
        total++; if (bus1.done !== 1'b1 || bus1.cpu_reset !== 1'b0 || bus1.mem_we !== 1'b0) begin bad++; $display("FAIL one_done got done=%0h cr=%0h we=%0h exp 1 0 0", bus1.done, bus1.cpu_reset, bus1.mem_we); end
    endtask

`ifdef DMEM_LOADER_CHECKSUM_EN
    // Words 0..95 sum to 4560 = 0x11D0; cleared by the next start
    task automatic test_checksum();
        pulse_start();
        total++; if (bus.checksum !== 32'd0) begin bad++; $display("FAIL ck_clear0 got=%0h exp=0", bus.checksum); end
        for (int i = 0; i < 96; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        total++; if (bus.checksum !== 32'h0000_11D0) begin bad++; $display("FAIL ck_sum got=%0h exp=11d0", bus.checksum); end
        pulse_start();
        total++; if (bus.checksum !== 32'd0) begin bad++; $display("FAIL ck_restart got=%0h exp=0", bus.checksum); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 32'h0;
        test_reset();
        test_back_to_back();
        test_stalls();
        test_reload_done();
        test_start_ignored();
        test_reset_mid();
        test_num_words_one();
`ifdef DMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_loader
`default_nettype wire
